// File: rtl/display_pkg.sv
// Timing constants for 640x480@60 (800x525 total) and the generator state type.
// Also holds a helper that maps an active/inactive condition onto a sync polarity.
package display_pkg;

    localparam int DT_CORDW    = 10;
    localparam int DT_FCNTW    = 16;

    localparam int DT_H_ACTIVE = 640;
    localparam int DT_H_FP     = 16;
    localparam int DT_H_SYNC   = 96;
    localparam int DT_H_BP     = 48;
    localparam int DT_V_ACTIVE = 480;
    localparam int DT_V_FP     = 10;
    localparam int DT_V_SYNC   = 2;
    localparam int DT_V_BP     = 33;

    localparam int DT_H_TOTAL  = DT_H_ACTIVE + DT_H_FP + DT_H_SYNC + DT_H_BP;
    localparam int DT_V_TOTAL  = DT_V_ACTIVE + DT_V_FP + DT_V_SYNC + DT_V_BP;
    localparam int DT_HS_START = DT_H_ACTIVE + DT_H_FP;
    localparam int DT_HS_END   = DT_HS_START + DT_H_SYNC - 1;
    localparam int DT_VS_START = DT_V_ACTIVE + DT_V_FP;
    localparam int DT_VS_END   = DT_VS_START + DT_V_SYNC - 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timing_state_e;

    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/display_timing_480p_if.sv
// Video timing bundle from the generator to the drawing logic / capture.
// All signals are registered by the generator and describe the pixel at (sx, sy).
interface display_timing_480p_if #(
    parameter int CORDW = 10,
    parameter int FCNTW = 16
);
    logic [CORDW-1:0] sx;
    logic [CORDW-1:0] sy;
    logic             de;
    logic             hsync;
    logic             vsync;
    logic             line;
    logic             frame;
    logic [FCNTW-1:0] frame_cnt;

    modport master (
        output sx, sy, de, hsync, vsync, line, frame, frame_cnt
    );

    modport slave (
        input  sx, sy, de, hsync, vsync, line, frame, frame_cnt
    );
endinterface

// File: rtl/display_timing_480p.sv
// Pixel-clock raster timing generator; every output is registered and aligned with sx/sy.
// Free-running once out of reset: no handshake, no backpressure.
module display_timing_480p
    import display_pkg::*;
#(
    parameter int CORDW    = DT_CORDW,
    parameter int H_ACTIVE = DT_H_ACTIVE,
    parameter int H_FP     = DT_H_FP,
    parameter int H_SYNC   = DT_H_SYNC,
    parameter int H_BP     = DT_H_BP,
    parameter int V_ACTIVE = DT_V_ACTIVE,
    parameter int V_FP     = DT_V_FP,
    parameter int V_SYNC   = DT_V_SYNC,
    parameter int V_BP     = DT_V_BP,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int FCNTW    = DT_FCNTW
) (
    input  logic                   clk_pix,
    input  logic                   sim_rst_n,
    display_timing_480p_if.master  o_vid
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam logic [CORDW-1:0] C_H_MAX    = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] C_V_MAX    = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] C_H_ACTIVE = CORDW'(H_ACTIVE);
    localparam logic [CORDW-1:0] C_V_ACTIVE = CORDW'(V_ACTIVE);
    localparam logic [CORDW-1:0] C_HS_START = CORDW'(HS_START);
    localparam logic [CORDW-1:0] C_HS_END   = CORDW'(HS_END);
    localparam logic [CORDW-1:0] C_VS_START = CORDW'(VS_START);
    localparam logic [CORDW-1:0] C_VS_END   = CORDW'(VS_END);

    if (H_TOTAL > (1 << CORDW)) begin : g_chk_h
        $error("display_timing_480p: H_TOTAL does not fit in CORDW bits");
    end
    if (V_TOTAL > (1 << CORDW)) begin : g_chk_v
        $error("display_timing_480p: V_TOTAL does not fit in CORDW bits");
    end

    timing_state_e    r_state;
    timing_state_e    w_state_nxt;

    logic [CORDW-1:0] r_sx;
    logic [CORDW-1:0] r_sy;
    logic [CORDW-1:0] w_sx_nxt;
    logic [CORDW-1:0] w_sy_nxt;
    logic             w_frame_nxt;

    logic             r_de;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_line;
    logic             r_frame;
    logic [FCNTW-1:0] r_frame_cnt;

    always_ff @(posedge clk_pix or negedge sim_rst_n) begin
        if (!sim_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The IDLE->RUN edge loads (0,0); counting starts from the following edge.
    always_comb begin
        w_state_nxt = r_state;
        w_sx_nxt    = '0;
        w_sy_nxt    = '0;
        case (r_state)
            IDLE: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                w_state_nxt = RUN;
                if (r_sx == C_H_MAX) begin
                    w_sx_nxt = '0;
                    w_sy_nxt = (r_sy == C_V_MAX) ? '0 : r_sy + 1'b1;
                end else begin
                    w_sx_nxt = r_sx + 1'b1;
                    w_sy_nxt = r_sy;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_frame_nxt = (w_sx_nxt == '0) && (w_sy_nxt == '0);
    end

    always_ff @(posedge clk_pix or negedge sim_rst_n) begin
        if (!sim_rst_n) begin
            r_sx <= '0;
            r_sy <= '0;
        end else begin
            r_sx <= w_sx_nxt;
            r_sy <= w_sy_nxt;
        end
    end

    // Decode from the next coordinates so the flops land in step with r_sx/r_sy.
    always_ff @(posedge clk_pix or negedge sim_rst_n) begin
        if (!sim_rst_n) begin
            r_de        <= 1'b0;
            r_hsync     <= ~H_POL;
            r_vsync     <= ~V_POL;
            r_line      <= 1'b0;
            r_frame     <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_de    <= (w_sx_nxt < C_H_ACTIVE) && (w_sy_nxt < C_V_ACTIVE);
            r_hsync <= sync_level((w_sx_nxt >= C_HS_START) && (w_sx_nxt <= C_HS_END), H_POL);
            r_vsync <= sync_level((w_sy_nxt >= C_VS_START) && (w_sy_nxt <= C_VS_END), V_POL);
            r_line  <= (w_sx_nxt == '0);
            r_frame <= w_frame_nxt;
            // The frame loaded on leaving IDLE is not a completed frame.
            if (w_frame_nxt && (r_state == RUN)) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign o_vid.sx        = r_sx;
    assign o_vid.sy        = r_sy;
    assign o_vid.de        = r_de;
    assign o_vid.hsync     = r_hsync;
    assign o_vid.vsync     = r_vsync;
    assign o_vid.line      = r_line;
    assign o_vid.frame     = r_frame;
    assign o_vid.frame_cnt = r_frame_cnt;

endmodule
